branch_resolve_unit: RTL and testbench



---
 rtl/branch_pkg.sv | 20 ++
 rtl/branch_resolve_unit_if.sv | 30 +++
 rtl/branch_cmp.sv | 36 +++
 rtl/branch_resolve_unit.sv | 90 +++++++++
 tb/tb_branch_resolve_unit.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and default widths for the branch resolution stage.
package branch_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_PC_WIDTH  = 16;
  localparam int DEF_OFF_WIDTH = 8;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    COND_LT     = 3'b000,
    COND_GT     = 3'b001,
    COND_EQ     = 3'b010,
    COND_NE     = 3'b011,
    COND_LE     = 3'b100,
    COND_GE     = 3'b101,
    COND_ALWAYS = 3'b110,
    COND_NEVER  = 3'b111
  } cond_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result handshake bundle between decode, branch resolution and PC select.
interface branch_resolve_unit_if #(
  parameter int WIDTH     = 16,
  parameter int PC_WIDTH  = 16,
  parameter int OFF_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           cond;
  logic                 is_signed;
  logic [WIDTH-1:0]     op1;
  logic [WIDTH-1:0]     r15;
  logic [PC_WIDTH-1:0]  pc;
  logic [OFF_WIDTH-1:0] offset;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic                 taken;
  logic [PC_WIDTH-1:0]  target;

  modport slave (
    input  in_valid, cond, is_signed, op1, r15, pc, offset, flush, out_ready,
    output in_ready, out_valid, taken, target
  );

  modport master (
    output in_valid, cond, is_signed, op1, r15, pc, offset, flush, out_ready,
    input  in_ready, out_valid, taken, target
  );
endinterface

// File: rtl/branch_cmp.sv
// Combinational condition evaluator: signed or unsigned compare of op1 against r15.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  cond_t            cond,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] r15,
  output logic             taken
);

  logic lt;
  logic eq;

  // Every condition is derived from a single less-than and a single equality.
  always_comb begin
    eq = (op1 == r15);
    if (is_signed) lt = ($signed(op1) < $signed(r15));
    else           lt = (op1 < r15);
    taken = 1'b0;
    case (cond)
      COND_LT:     taken = lt;
      COND_GT:     taken = !lt && !eq;
      COND_EQ:     taken = eq;
      COND_NE:     taken = !eq;
      COND_LE:     taken = lt || eq;
      COND_GE:     taken = !lt;
      COND_ALWAYS: taken = 1'b1;
      COND_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage with valid/ready output and flush.
// Optional taken/not-taken statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int PC_WIDTH  = DEF_PC_WIDTH,
  parameter int OFF_WIDTH = DEF_OFF_WIDTH
`ifdef BRANCH_STATS_EN
  ,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
`endif
) (
  input logic clk,
  input logic rst,
  branch_resolve_unit_if.slave bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_taken,
  output logic [CNT_WIDTH-1:0] stat_not_taken
`endif
);

  logic                 cmp_taken;
  logic                 accept;
  logic                 in_ready_c;
  logic [OFF_WIDTH-1:0] off_raw;
  logic [PC_WIDTH-1:0]  off_ext;
  logic [PC_WIDTH-1:0]  target_next;

  logic                 out_valid_q;
  logic                 taken_q;
  logic [PC_WIDTH-1:0]  target_q;

  branch_cmp #(.WIDTH(WIDTH)) u_cmp (
    .cond      (cond_t'(bus.cond)),
    .is_signed (bus.is_signed),
    .op1       (bus.op1),
    .r15       (bus.r15),
    .taken     (cmp_taken)
  );

  // Target arithmetic wraps modulo 2^PC_WIDTH by construction.
  always_comb begin
    in_ready_c  = !bus.flush && (!out_valid_q || bus.out_ready);
    accept      = bus.in_valid && in_ready_c;
    off_raw     = bus.offset;
    off_ext     = PC_WIDTH'($signed(off_raw));
    target_next = cmp_taken ? (bus.pc + off_ext) : (bus.pc + PC_WIDTH'(1));
  end

  // Flush wins over accept and drain; taken/target simply keep stale values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      taken_q     <= 1'b0;
      target_q    <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      taken_q     <= cmp_taken;
      target_q    <= target_next;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.taken     = taken_q;
  assign bus.target    = target_q;

`ifdef BRANCH_STATS_EN
  // Counted at accept time, so results flushed later are still included.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken     <= '0;
      stat_not_taken <= '0;
    end else if (accept) begin
      if (cmp_taken) begin
        if (stat_taken != '1) stat_taken <= stat_taken + CNT_WIDTH'(1);
      end else begin
        if (stat_not_taken != '1) stat_not_taken <= stat_not_taken + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit using a result scoreboard queue.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  typedef struct packed {
    logic        taken;
    logic [15:0] target;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.WIDTH(16), .PC_WIDTH(16), .OFF_WIDTH(8)) bus ();

`ifdef BRANCH_STATS_EN
  logic [3:0] stat_taken;
  logic [3:0] stat_not_taken;
`endif

  branch_resolve_unit #(
    .WIDTH(16), .PC_WIDTH(16), .OFF_WIDTH(8)
`ifdef BRANCH_STATS_EN
    , .CNT_WIDTH(4)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BRANCH_STATS_EN
    , .stat_taken     (stat_taken)
    , .stat_not_taken (stat_not_taken)
`endif
  );

  int   checks = 0;
  int   passes = 0;
  res_t exp_q[$];
  int   mdl_taken = 0;
  int   mdl_not = 0;

  function automatic res_t model(input logic [2:0] c, input logic s,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] p, input logic [7:0] o);
    int   sa, sb, t;
    logic tk;
    res_t r;
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    case (c)
      3'd0:    tk = (sa < sb);
      3'd1:    tk = (sa > sb);
      3'd2:    tk = (a == b);
      3'd3:    tk = (a != b);
      3'd4:    tk = (sa <= sb);
      3'd5:    tk = (sa >= sb);
      3'd6:    tk = 1'b1;
      default: tk = 1'b0;
    endcase
    if (tk) t = int'(p) + int'($signed(o));
    else    t = int'(p) + 1;
    r.taken  = tk;
    r.target = t[15:0];
    return r;
  endfunction

  task automatic drive(input logic v, input logic [2:0] c, input logic s,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] p, input logic [7:0] o);
    bus.in_valid  = v;
    bus.cond      = c;
    bus.is_signed = s;
    bus.op1       = a;
    bus.r15       = b;
    bus.pc        = p;
    bus.offset    = o;
  endtask

  // One clock: predict acceptance/drain from the bench's own view of the output register.
  task automatic tick();
    logic mv, acc;
    res_t r;
    mv  = (exp_q.size() != 0);
    acc = bus.in_valid && !bus.flush && (!mv || bus.out_ready);
    r   = model(bus.cond, bus.is_signed, bus.op1, bus.r15, bus.pc, bus.offset);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      mdl_taken = 0;
      mdl_not   = 0;
    end else if (bus.flush) begin
      exp_q.delete();
    end else begin
      if (mv && bus.out_ready) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(r);
        if (r.taken) mdl_taken = (mdl_taken < 15) ? mdl_taken + 1 : 15;
        else         mdl_not   = (mdl_not < 15) ? mdl_not + 1 : 15;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset out_valid: got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.taken !== 1'b0) $display("[TB] FAIL reset taken: got %b want 0", bus.taken); else passes++;
    checks++; if (bus.target !== 16'h0000) $display("[TB] FAIL reset target: got %h want 0000", bus.target); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset in_ready: got %b want 1", bus.in_ready); else passes++;
`ifdef BRANCH_STATS_EN
    checks++; if (stat_taken !== 4'h0) $display("[TB] FAIL reset stat_taken: got %h want 0", stat_taken); else passes++;
    checks++; if (stat_not_taken !== 4'h0) $display("[TB] FAIL reset stat_not_taken: got %h want 0", stat_not_taken); else passes++;
`endif
  endtask

  task automatic test_signed_unsigned();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd0, 1'b0, 16'hFFFF, 16'h0001, 16'h0010, 8'h04);
    tick();
    drive(1'b1, 3'd0, 1'b1, 16'hFFFF, 16'h0001, 16'h0010, 8'h04);
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL unsigned out_valid: got %b want 1", bus.out_valid); else passes++;
    checks++; if (bus.taken !== 1'b0 || bus.target !== 16'h0011)
      $display("[TB] FAIL unsigned lt: got %b/%h want 0/0011", bus.taken, bus.target); else passes++;
    tick();
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0);
    checks++; if (bus.taken !== 1'b1 || bus.target !== 16'h0014)
      $display("[TB] FAIL signed lt: got %b/%h want 1/0014", bus.taken, bus.target); else passes++;
    tick();
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL drain out_valid: got %b want 0", bus.out_valid); else passes++;
  endtask

  task automatic test_wrap();
    bus.out_ready = 1'b1;
    drive(1'b1, 3'd6, 1'b0, 16'h1234, 16'h5678, 16'h0002, 8'hFC);
    tick();
    drive(1'b1, 3'd7, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 8'h10);
    checks++; if (bus.taken !== 1'b1 || bus.target !== 16'hFFFE)
      $display("[TB] FAIL always wrap: got %b/%h want 1/fffe", bus.taken, bus.target); else passes++;
    tick();
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0);
    checks++; if (bus.taken !== 1'b0 || bus.target !== 16'h0000)
      $display("[TB] FAIL never wrap: got %b/%h want 0/0000", bus.taken, bus.target); else passes++;
    tick();
  endtask

  task automatic test_stall();
    int idx = 0;
    logic er;
    for (int c = 0; c < 10; c++) begin
      case (idx)
        0:       drive(1'b1, 3'd1, 1'b0, 16'h0005, 16'h0003, 16'h0100, 8'h10);
        1:       drive(1'b1, 3'd3, 1'b0, 16'h0007, 16'h0007, 16'h0200, 8'h22);
        2:       drive(1'b1, 3'd4, 1'b1, 16'h8000, 16'h0001, 16'h0300, 8'hF0);
        default: drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0);
      endcase
      bus.out_ready = (c >= 4);
      #1;
      er = !bus.flush && (exp_q.size() == 0 || bus.out_ready);
      checks++; if (bus.in_ready !== er) $display("[TB] FAIL stall in_ready c%0d: got %b want %b", c, bus.in_ready, er); else passes++;
      if (bus.in_valid && er) idx++;
      tick();
      checks++; if (bus.out_valid !== (exp_q.size() != 0))
        $display("[TB] FAIL stall out_valid c%0d: got %b want %b", c, bus.out_valid, exp_q.size() != 0); else passes++;
      if (exp_q.size() != 0) begin
        checks++; if ({bus.taken, bus.target} !== exp_q[0])
          $display("[TB] FAIL stall result c%0d: got %b/%h want %b/%h", c, bus.taken, bus.target, exp_q[0].taken, exp_q[0].target); else passes++;
      end
    end
    checks++; if (idx != 3) $display("[TB] FAIL stall consumed: got %0d want 3", idx); else passes++;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd2, 1'b0, 16'h00AA, 16'h00AA, 16'h0400, 8'h08);
    tick();
    drive(1'b1, 3'd5, 1'b1, 16'hFFF0, 16'h0002, 16'h0500, 8'h7F);
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL flush in_ready: got %b want 0", bus.in_ready); else passes++;
    tick();
    bus.flush = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL flush out_valid: got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL post-flush in_ready: got %b want 1", bus.in_ready); else passes++;
    tick();
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0);
    checks++; if (bus.out_valid !== 1'b1 || bus.taken !== 1'b0 || bus.target !== 16'h0501)
      $display("[TB] FAIL post-flush result: got %b %b/%h want 1 0/0501", bus.out_valid, bus.taken, bus.target); else passes++;
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic er;
    for (int c = 0; c < 60; c++) begin
      drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom), 16'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) bus.r15 = bus.op1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 7) == 0);
      #1;
      er = !bus.flush && (exp_q.size() == 0 || bus.out_ready);
      checks++; if (bus.in_ready !== er) $display("[TB] FAIL rand in_ready c%0d: got %b want %b", c, bus.in_ready, er); else passes++;
      tick();
      checks++; if (bus.out_valid !== (exp_q.size() != 0))
        $display("[TB] FAIL rand out_valid c%0d: got %b want %b", c, bus.out_valid, exp_q.size() != 0); else passes++;
      if (exp_q.size() != 0) begin
        checks++; if ({bus.taken, bus.target} !== exp_q[0])
          $display("[TB] FAIL rand result c%0d: got %b/%h want %b/%h", c, bus.taken, bus.target, exp_q[0].taken, exp_q[0].target); else passes++;
      end
    end
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0);
    tick();
`ifdef BRANCH_STATS_EN
    checks++; if (stat_taken !== 4'(mdl_taken)) $display("[TB] FAIL rand stat_taken: got %h want %h", stat_taken, 4'(mdl_taken)); else passes++;
    checks++; if (stat_not_taken !== 4'(mdl_not)) $display("[TB] FAIL rand stat_not_taken: got %h want %h", stat_not_taken, 4'(mdl_not)); else passes++;
`endif
  endtask

  task automatic test_reset_during_stall();
    bus.out_ready = 1'b0;
    drive(1'b1, 3'd6, 1'b0, 16'h0, 16'h0, 16'h0700, 8'h05);
    tick();
    checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL pre-rst out_valid: got %b want 1", bus.out_valid); else passes++;
    drive(1'b1, 3'd6, 1'b0, 16'h0, 16'h0, 16'h0800, 8'h05);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0);
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.taken !== 1'b0 || bus.target !== 16'h0000)
      $display("[TB] FAIL rst stall: got %b %b/%h want 0 0/0000", bus.out_valid, bus.taken, bus.target); else passes++;
    bus.out_ready = 1'b1;
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_counters();
    logic [15:0] v;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      v = 16'($urandom);
      drive(1'b1, 3'd2, 1'($urandom_range(0, 1)), v, v, 16'($urandom), 8'($urandom));
      tick();
      if (i == 9) begin
        checks++; if (stat_taken !== 4'hA) $display("[TB] FAIL cnt mid taken: got %h want a", stat_taken); else passes++;
      end
    end
    drive(1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 16'h0, 8'h0);
    tick();
    checks++; if (stat_taken !== 4'hF) $display("[TB] FAIL cnt saturate taken: got %h want f", stat_taken); else passes++;
    checks++; if (stat_not_taken !== 4'h0) $display("[TB] FAIL cnt not_taken: got %h want 0", stat_not_taken); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_signed_unsigned();
    test_wrap();
    test_stall();
    test_flush();
    test_random();
    test_reset_during_stall();
`ifdef BRANCH_STATS_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
